n_run_packer: RTL and testbench

- Run-length packer: the encoder-side counterpart to the N-run expander, which takes a 160-bit {data, count} record and replays the data word count times.
- Accepts a stream of 128-bit words under a valid/ready handshake and collapses runs of identical consecutive words into 160-bit records.
- Each record is {word[127:0], count[31:0]}: bits 159:32 hold the word, bits 31:0 hold the count.
- Sits in the compression path ahead of record storage; its records feed the expander unchanged.

---
 rtl/n_run_pkg.sv | 14 +
 rtl/n_run_packer_if.sv | 27 ++
 rtl/n_run_out_slot.sv | 29 ++
 rtl/n_run_packer.sv | 96 +++++++++
 tb/tb_n_run_packer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/n_run_pkg.sv
// Shared widths, record layout and FSM states for the N-run packer.
package n_run_pkg;
    localparam int DATA_W = 128;
    localparam int CNT_W  = 32;
    localparam int REC_W  = DATA_W + CNT_W;

    // Record as seen by the expander: word in the upper bits, count below.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CNT_W-1:0]  count;
    } rec_t;

    typedef enum logic [1:0] {EMPTY, ACCUM, FLUSHING} state_t;
endpackage

// File: rtl/n_run_packer_if.sv
// Stream-in / record-out bundle of the N-run packer.
interface n_run_packer_if #(
    parameter int DATA_W = 128,
    parameter int CNT_W  = 32
) ();
    logic [DATA_W-1:0]       in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic                    flush;
    logic [DATA_W+CNT_W-1:0] rec;
    logic                    rec_valid;
    logic                    rec_ready;
    logic                    flush_done;
    logic [31:0]             rec_total;

    // Packer side.
    modport slave (
        input  in_data, in_valid, flush, rec_ready,
        output in_ready, rec, rec_valid, flush_done, rec_total
    );

    // Source/sink side.
    modport master (
        output in_data, in_valid, flush, rec_ready,
        input  in_ready, rec, rec_valid, flush_done, rec_total
    );
endinterface

// File: rtl/n_run_out_slot.sv
// One-entry output register: loads replace the held record, a handshake
// without a load empties it.
module n_run_out_slot #(
    parameter int W = 160
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic         slot_free
);
    assign slot_free = !valid || ready;

    // Hold the record until taken; a same-cycle load overwrites with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            dout  <= din;
            valid <= 1'b1;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/n_run_packer.sv
// Collapses runs of identical stream words into {word, count} records.
module n_run_packer
    import n_run_pkg::*;
#(
    parameter int               DATA_W  = n_run_pkg::DATA_W,
    parameter int               CNT_W   = n_run_pkg::CNT_W,
    parameter logic [CNT_W-1:0] MAX_RUN = '1
) (
    input logic           clk,
    input logic           rst_n,
    n_run_packer_if.slave bus
);
    state_t            state;
    logic [DATA_W-1:0] run_data;
    logic [CNT_W-1:0]  run_cnt;
    logic              slot_free;
    logic              match;
    logic              accept;
    logic              load;
    logic              in_ready;
    logic              flush_done;
    logic [31:0]       rec_total;

    // A matching word needs no output slot, so it is taken even under
    // backpressure; anything that closes a run must wait for the slot.
    always_comb begin
        match    = (state == ACCUM) && (bus.in_data == run_data) && (run_cnt < MAX_RUN);
        in_ready = 1'b0;
        case (state)
            EMPTY:    in_ready = 1'b1;
            ACCUM:    in_ready = !bus.flush && (match || slot_free);
            default:  in_ready = 1'b0;
        endcase
        accept = bus.in_valid && in_ready;
        load   = ((state == ACCUM) && accept && !match) ||
                 ((state == FLUSHING) && slot_free);
    end

    n_run_out_slot #(.W(DATA_W + CNT_W)) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .din       ({run_data, run_cnt}),
        .ready     (bus.rec_ready),
        .dout      (bus.rec),
        .valid     (bus.rec_valid),
        .slot_free (slot_free)
    );

    // Run tracking FSM with registered flush_done pulse and record counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            run_data   <= '0;
            run_cnt    <= '0;
            flush_done <= 1'b0;
            rec_total  <= '0;
        end else begin
            flush_done <= 1'b0;
            if (load) rec_total <= rec_total + 32'd1;
            case (state)
                EMPTY: begin
                    if (bus.flush) flush_done <= 1'b1;
                    if (accept) begin
                        run_data <= bus.in_data;
                        run_cnt  <= CNT_W'(1);
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (bus.flush) begin
                        state <= FLUSHING;
                    end else if (accept) begin
                        if (match) begin
                            run_cnt <= run_cnt + CNT_W'(1);
                        end else begin
                            run_data <= bus.in_data;
                            run_cnt  <= CNT_W'(1);
                        end
                    end
                end
                default: begin
                    if (slot_free) begin
                        flush_done <= 1'b1;
                        run_cnt    <= '0;
                        state      <= EMPTY;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.flush_done = flush_done;
    assign bus.rec_total  = rec_total;
endmodule

// File: tb/tb_n_run_packer.sv
// Bench for n_run_packer: directed scenarios plus random traffic, all checked
// against a run-list reference model.
module tb_n_run_packer;
    import n_run_pkg::*;

    localparam logic [31:0] MAXR = 32'd3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    n_run_packer_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
    n_run_packer #(.DATA_W(DATA_W), .CNT_W(CNT_W), .MAX_RUN(MAXR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [REC_W-1:0] got, input logic [REC_W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: the open run, a pending flush, records produced but not
    // yet taken, and records taken by the sink.
    bit           m_has, m_flsh;
    logic [127:0] m_data;
    int unsigned  m_cnt, m_total;
    rec_t         q[$];
    rec_t         seen[$];
    bit           hold;
    logic [REC_W-1:0] hold_rec;
    bit           last_ir;
    logic [127:0] A, B;

    function automatic rec_t mk(input logic [127:0] d, input int unsigned c);
        rec_t r;
        r.data  = d;
        r.count = c;
        return r;
    endfunction

    task automatic push_run();
        q.push_back(mk(m_data, m_cnt));
        m_total++;
    endtask

    task automatic step(input bit v, input logic [127:0] d, input bit f, input bit rr);
        bit sf, match, eir, acc, fd;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.flush     = f;
        bus.rec_ready = rr;
        @(negedge clk);
        sf    = !bus.rec_valid || rr;
        match = m_has && (d == m_data) && (m_cnt < MAXR);
        eir   = m_flsh ? 1'b0 : !m_has ? 1'b1 : f ? 1'b0 : (match || sf);
        chk("in_ready", REC_W'(bus.in_ready), REC_W'(eir));
        last_ir = bus.in_ready;
        if (hold) begin
            chk("rec_stable", bus.rec, hold_rec);
            chk("valid_stable", REC_W'(bus.rec_valid), REC_W'(1));
        end
        hold     = bus.rec_valid && !rr;
        hold_rec = bus.rec;
        acc = v && eir;
        if (bus.rec_valid && rr) begin
            chk("q_depth", REC_W'(q.size()), REC_W'(1));
            if (q.size() != 0) seen.push_back(q.pop_front());
        end
        fd = 1'b0;
        if (m_flsh) begin
            if (sf) begin
                push_run();
                m_has = 0; m_flsh = 0; fd = 1'b1;
            end
        end else if (!m_has) begin
            if (f) fd = 1'b1;
            if (acc) begin m_has = 1; m_data = d; m_cnt = 1; end
        end else if (f) begin
            m_flsh = 1;
        end else if (acc) begin
            if (match) m_cnt++;
            else begin push_run(); m_data = d; m_cnt = 1; end
        end
        @(posedge clk);
        #1;
        chk("flush_done", REC_W'(bus.flush_done), REC_W'(fd));
        chk("rec_total", REC_W'(bus.rec_total), REC_W'(m_total));
        chk("rec_valid", REC_W'(bus.rec_valid), REC_W'(q.size() != 0));
        if (q.size() != 0) chk("rec", bus.rec, q[0]);
    endtask

    task automatic drain();
        repeat (4) step(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.flush     = 1'b0;
        bus.rec_ready = 1'b0;
        rst_n = 1'b0;
        #3;
        chk("rst_rec_valid", REC_W'(bus.rec_valid), REC_W'(0));
        chk("rst_rec_total", REC_W'(bus.rec_total), REC_W'(0));
        chk("rst_flush_done", REC_W'(bus.flush_done), REC_W'(0));
        chk("rst_rec", bus.rec, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_has = 0; m_flsh = 0; m_cnt = 0; m_total = 0; hold = 0;
        q.delete();
        @(posedge clk);
        #1;
        chk("rst_in_ready", REC_W'(bus.in_ready), REC_W'(1));
    endtask

    initial begin
        A = {$urandom, $urandom, $urandom, $urandom};
        B = ~A;
        do_reset();

        // A,A,A,B + flush -> {A,3},{B,1}
        seen.delete();
        repeat (3) step(1'b1, A, 1'b0, 1'b1);
        step(1'b1, B, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        drain();
        chk("t1_n", REC_W'(seen.size()), REC_W'(2));
        if (seen.size() == 2) begin
            chk("t1_r0", seen[0], {A, 32'd3});
            chk("t1_r1", seen[1], {B, 32'd1});
        end
        chk("t1_total", REC_W'(bus.rec_total), REC_W'(2));

        // Alternating words: one record each, never stalling
        seen.delete();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, (i % 2) ? B : A, 1'b0, 1'b1);
            chk("t2_nobubble", REC_W'(last_ir), REC_W'(1));
        end
        step(1'b0, '0, 1'b1, 1'b1);
        drain();
        chk("t2_n", REC_W'(seen.size()), REC_W'(4));
        foreach (seen[i]) chk("t2_cnt", REC_W'(seen[i].count), REC_W'(1));

        // Saturation at MAX_RUN=3: seven A -> {A,3},{A,3},{A,1}
        seen.delete();
        repeat (7) step(1'b1, A, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        drain();
        chk("t3_n", REC_W'(seen.size()), REC_W'(3));
        if (seen.size() == 3) begin
            chk("t3_r0", seen[0], {A, 32'd3});
            chk("t3_r1", seen[1], {A, 32'd3});
            chk("t3_r2", seen[2], {A, 32'd1});
        end

        // Backpressure: matching words pass, a new word waits for the slot
        seen.delete();
        step(1'b1, B, 1'b0, 1'b1);
        step(1'b1, A, 1'b0, 1'b1);
        step(1'b1, A, 1'b0, 1'b0);
        chk("t4_match_ir", REC_W'(last_ir), REC_W'(1));
        step(1'b1, A, 1'b0, 1'b0);
        chk("t4_match_ir2", REC_W'(last_ir), REC_W'(1));
        repeat (3) begin
            step(1'b1, B, 1'b0, 1'b0);
            chk("t4_block_ir", REC_W'(last_ir), REC_W'(0));
            chk("t4_held", bus.rec, {B, 32'd1});
        end
        step(1'b1, B, 1'b0, 1'b1);
        chk("t4_release_ir", REC_W'(last_ir), REC_W'(1));
        chk("t4_next", bus.rec, {A, 32'd3});
        step(1'b0, '0, 1'b1, 1'b1);
        drain();
        chk("t4_n", REC_W'(seen.size()), REC_W'(3));

        // Flush while empty, then flush racing an input word
        seen.delete();
        step(1'b0, '0, 1'b1, 1'b1);
        chk("t5_fd", REC_W'(bus.flush_done), REC_W'(1));
        chk("t5_novalid", REC_W'(bus.rec_valid), REC_W'(0));
        step(1'b1, A, 1'b0, 1'b1);
        step(1'b1, B, 1'b1, 1'b1);
        chk("t5_flush_ir", REC_W'(last_ir), REC_W'(0));
        drain();
        chk("t5_n", REC_W'(seen.size()), REC_W'(1));
        if (seen.size() == 1) chk("t5_r0", seen[0], {A, 32'd1});

        // Reset mid-run with a held record
        step(1'b1, A, 1'b0, 1'b1);
        step(1'b1, B, 1'b0, 1'b0);
        chk("t6_pre_valid", REC_W'(bus.rec_valid), REC_W'(1));
        do_reset();
        seen.delete();
        step(1'b1, B, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        drain();
        chk("t6_n", REC_W'(seen.size()), REC_W'(1));
        if (seen.size() == 1) chk("t6_r0", seen[0], {B, 32'd1});

        // Random traffic from a small alphabet so runs form and split
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 2) == 0) ? B : A,
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 3) != 0);
        end
        step(1'b0, '0, 1'b1, 1'b1);
        drain();
        chk("rand_empty", REC_W'(q.size()), REC_W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
